// File: rtl/arm_dp_sequencer_pkg.sv
// Shared definitions for the ARM data-processing sequencer: FSM states,
// condition codes, opcode constants, RSLCT field offsets and decode helpers.
package arm_dp_sequencer_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WRITE  = 2'd3
  } state_e;

  // ARM condition field encodings
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Compare-class opcodes: they only produce flags, never a register write
  localparam logic [3:0] OPC_TST = 4'd8;
  localparam logic [3:0] OPC_TEQ = 4'd9;
  localparam logic [3:0] OPC_CMP = 4'd10;
  localparam logic [3:0] OPC_CMN = 4'd11;

  // Default ALU opcode when nothing is issued
  localparam logic [4:0] OP_IDLE_DEFAULT = 5'd17;

  // Flag bit positions inside {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Low bit of each 4-bit register select inside RSLCT
  localparam int RSL_RN_LO  = 0;
  localparam int RSL_RM_LO  = 4;
  localparam int RSL_RS_LO  = 8;
  localparam int RSL_RD_LO  = 12;
  localparam int RSL_RN2_LO = 16;

  // Opcode falls in TST..CMN
  function automatic logic is_compare_op(input logic [3:0] opc);
    return (opc >= OPC_TST) && (opc <= OPC_CMN);
  endfunction

  // Register-register, unshifted data-processing form only.
  // cls = IR[27:25], shift = IR[11:4]
  function automatic logic dp_supported(input logic [2:0] cls, input logic [7:0] shift);
    return (cls == 3'b000) && (shift == 8'h00);
  endfunction

endpackage

// File: rtl/arm_dp_sequencer_cond_check.sv
// Combinational ARM condition-code evaluator against the current NZCV flags.
module arm_cond_check
  import arm_dp_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n_f, z_f, c_f, v_f;

  assign n_f = nzcv[FLAG_N];
  assign z_f = nzcv[FLAG_Z];
  assign c_f = nzcv[FLAG_C];
  assign v_f = nzcv[FLAG_V];

  // Condition decode; NV never passes
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_f;
      COND_NE: pass = !z_f;
      COND_CS: pass = c_f;
      COND_CC: pass = !c_f;
      COND_MI: pass = n_f;
      COND_PL: pass = !n_f;
      COND_VS: pass = v_f;
      COND_VC: pass = !v_f;
      COND_HI: pass = c_f && !z_f;
      COND_LS: pass = !c_f || z_f;
      COND_GE: pass = (n_f == v_f);
      COND_LT: pass = (n_f != v_f);
      COND_GT: pass = !z_f && (n_f == v_f);
      COND_LE: pass = z_f || (n_f != v_f);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_dp_sequencer.sv
// Control sequencer for register-form ARM data-processing instructions:
// accepts an instruction, checks support and condition, then drives the
// RegisterFile/ALU controls through EXEC and WRITE, capturing flags into CPSR.
module arm_dp_sequencer
  import arm_dp_sequencer_pkg::*;
#(
  parameter logic [4:0] OP_IDLE  = OP_IDLE_DEFAULT,
  parameter logic [3:0] CPSR_RST = 4'h0
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic [31:0] IR_in,
  input  logic        IR_valid,
  output logic        IR_ready,
  input  logic [3:0]  FLAGS_OUT,
  output logic [3:0]  FLAGS,
  output logic [19:0] RSLCT,
  output logic [4:0]  OP,
  output logic        S,
  output logic        ALU_OUT,
  output logic        LOAD,
  output logic        LOADPC,
  output logic        IR_CU,
  output logic        done,
  output logic        undef
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  cpsr_q, cpsr_d;
  logic        ir_cu_q, ir_cu_d;

  logic        cond_pass;
  logic        supported;
  logic        cmp_class;
  logic        rd_is_pc;
  logic [19:0] rslct_fields;

  arm_cond_check u_cond_check (
    .cond (ir_q[31:28]),
    .nzcv (cpsr_q),
    .pass (cond_pass)
  );

  // Field decode of the latched instruction
  always_comb begin
    supported    = dp_supported(ir_q[27:25], ir_q[11:4]);
    cmp_class    = is_compare_op(ir_q[24:21]);
    rd_is_pc     = (ir_q[15:12] == 4'hF);
    rslct_fields = '0;
    rslct_fields[RSL_RN_LO  +: 4] = ir_q[19:16];
    rslct_fields[RSL_RM_LO  +: 4] = ir_q[3:0];
    rslct_fields[RSL_RS_LO  +: 4] = ir_q[11:8];
    rslct_fields[RSL_RD_LO  +: 4] = ir_q[15:12];
    rslct_fields[RSL_RN2_LO +: 4] = ir_q[19:16];
  end

  // Next-state, register updates and output decode
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cpsr_d   = cpsr_q;
    ir_cu_d  = 1'b1;
    IR_ready = 1'b0;
    RSLCT    = '0;
    OP       = OP_IDLE;
    S        = 1'b0;
    ALU_OUT  = 1'b0;
    LOAD     = 1'b0;
    LOADPC   = 1'b0;
    done     = 1'b0;
    undef    = 1'b0;
    FLAGS    = cpsr_q;
    IR_CU    = ir_cu_q;

    unique case (state_q)
      ST_IDLE: begin
        IR_ready = 1'b1;
        if (IR_valid) begin
          ir_d    = IR_in;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        RSLCT = rslct_fields;
        if (!supported) begin
          undef   = 1'b1;
          state_d = ST_IDLE;
        end else if (!cond_pass) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        RSLCT   = rslct_fields;
        OP      = {1'b0, ir_q[24:21]};
        S       = ir_q[20];
        ALU_OUT = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        RSLCT   = rslct_fields;
        OP      = {1'b0, ir_q[24:21]};
        S       = ir_q[20];
        ALU_OUT = 1'b1;
        LOAD    = !cmp_class && !rd_is_pc;
        LOADPC  = !cmp_class && rd_is_pc;
        if (ir_q[20]) begin
          cpsr_d = FLAGS_OUT;
        end
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, instruction, CPSR and IR_CU registers; reset aborts any sequence
  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cpsr_q  <= CPSR_RST;
      ir_cu_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cpsr_q  <= cpsr_d;
      ir_cu_q <= ir_cu_d;
    end
  end

endmodule

// File: tb/tb_arm_dp_sequencer.sv
// Scoreboard bench for arm_dp_sequencer: the driver predicts each
// instruction's outcome from ARM rules and queues it; the monitor pops and
// compares whenever the sequencer retires (done) or rejects (undef).
module tb_arm_dp_sequencer;

  logic        Clk = 1'b0;
  logic        RESET;
  logic [31:0] IR_in;
  logic        IR_valid;
  logic        IR_ready;
  logic [3:0]  FLAGS_OUT;
  logic [3:0]  FLAGS;
  logic [19:0] RSLCT;
  logic [4:0]  OP;
  logic        S, ALU_OUT, LOAD, LOADPC, IR_CU, done, undef;

  arm_dp_sequencer dut (
    .Clk(Clk), .RESET(RESET), .IR_in(IR_in), .IR_valid(IR_valid),
    .IR_ready(IR_ready), .FLAGS_OUT(FLAGS_OUT), .FLAGS(FLAGS), .RSLCT(RSLCT),
    .OP(OP), .S(S), .ALU_OUT(ALU_OUT), .LOAD(LOAD), .LOADPC(LOADPC),
    .IR_CU(IR_CU), .done(done), .undef(undef)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] ir;
    bit          is_undef;
    int          lat;
    bit          load, loadpc, alu;
    logic [4:0]  op;
    bit          s;
    logic [19:0] rslct;
    logic [3:0]  flags;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  cpsr_m;
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ARM condition semantics over {N,Z,C,V}
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t predict(input logic [31:0] ir);
    exp_t e;
    bit   ok_form, is_cmp;
    e.ir = ir; e.flags = cpsr_m;
    e.is_undef = 0; e.lat = 1; e.load = 0; e.loadpc = 0; e.alu = 0;
    e.op = 5'd17; e.s = 0; e.rslct = '0;
    ok_form = (ir[27:26] == 2'b00) && (ir[25] == 1'b0) && (ir[11:4] == 8'h00);
    if (!ok_form) begin
      e.is_undef = 1;
    end else if (cond_ok(ir[31:28], cpsr_m)) begin
      is_cmp  = (ir[24:21] >= 4'd8) && (ir[24:21] <= 4'd11);
      e.lat   = 3;
      e.alu   = 1;
      e.op    = {1'b0, ir[24:21]};
      e.s     = ir[20];
      e.rslct = {ir[19:16], ir[15:12], ir[11:8], ir[3:0], ir[19:16]};
      e.load  = !is_cmp && (ir[15:12] != 4'hF);
      e.loadpc = !is_cmp && (ir[15:12] == 4'hF);
    end
    return e;
  endfunction

  // Present an instruction (IR_valid may already be high from the previous
  // one); once the sequencer is idle, drive its ALU flags and queue the
  // expectation, then let the next edge accept it. Called at posedge+1.
  task automatic issue(input logic [31:0] ir, input logic [3:0] fo);
    exp_t e;
    int   w;
    IR_in = ir;
    IR_valid = 1'b1;
    w = 0;
    while (!IR_ready && w < 20) begin
      @(posedge Clk); #1;
      w++;
    end
    if (!IR_ready) begin
      chk("ready_timeout", {31'd0, IR_ready}, 32'd1);
      IR_valid = 1'b0;
      return;
    end
    FLAGS_OUT = fo;
    e = predict(ir);
    sb.push_back(e);
    if (!e.is_undef && e.lat == 3 && ir[20]) cpsr_m = fo;
    @(posedge Clk); #1;
  endtask

  // Monitor state
  bit          in_flight = 0;
  int          cyc, ntx = 0;
  bit          ld_seen, ldpc_seen, alu_seen, rdy_seen;
  logic [3:0]  fl_dec;

  always @(negedge Clk) begin
    exp_t e;
    if (!mon_en || !RESET) begin
      in_flight = 0;
    end else begin
      if (in_flight) begin
        cyc++;
        ld_seen   |= LOAD;
        ldpc_seen |= LOADPC;
        alu_seen  |= ALU_OUT;
        if (cyc == 1) fl_dec = FLAGS;
        if (done || undef) begin
          in_flight = 0;
          if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            ntx++;
            $display("txn %0d: ir=%08h undef=%0d lat=%0d load=%0d loadpc=%0d op=%0d flags=%0h",
                     ntx, e.ir, undef, cyc, ld_seen, ldpc_seen, OP, fl_dec);
            chk("undef", {31'd0, undef}, {31'd0, e.is_undef});
            chk("done", {31'd0, done}, {31'd0, !e.is_undef});
            chk("latency", cyc, e.lat);
            chk("load", {31'd0, ld_seen}, {31'd0, e.load});
            chk("loadpc", {31'd0, ldpc_seen}, {31'd0, e.loadpc});
            chk("alu_out", {31'd0, alu_seen}, {31'd0, e.alu});
            chk("flags_decode", {28'd0, fl_dec}, {28'd0, e.flags});
            chk("ready_busy", {31'd0, rdy_seen}, 32'd0);
            if (!e.is_undef && e.lat == 3) begin
              chk("op", {27'd0, OP}, {27'd0, e.op});
              chk("s", {31'd0, S}, {31'd0, e.s});
              chk("rslct", {12'd0, RSLCT}, {12'd0, e.rslct});
            end
          end
        end else begin
          rdy_seen |= IR_ready;
          if (cyc >= 6) begin
            chk("retire_timeout", 32'd0, 32'd1);
            in_flight = 0;
          end
        end
      end else if (done || undef) begin
        chk("spurious_retire", 32'd1, 32'd0);
      end
      if (!in_flight && IR_valid && IR_ready) begin
        in_flight = 1; cyc = 0;
        ld_seen = 0; ldpc_seen = 0; alu_seen = 0; rdy_seen = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ir;
    logic [31:0] dir_ir[7];
    logic [3:0]  dir_fo[7];
    bit          wr_seen;

    RESET = 1'b0; IR_in = '0; IR_valid = 1'b0; FLAGS_OUT = '0;
    cpsr_m = 4'h0;
    #1;
    chk("rst_ir_ready", {31'd0, IR_ready}, 32'd1);
    chk("rst_op", {27'd0, OP}, 32'd17);
    chk("rst_ir_cu", {31'd0, IR_CU}, 32'd0);
    chk("rst_flags", {28'd0, FLAGS}, 32'd0);
    chk("rst_rslct", {12'd0, RSLCT}, 32'd0);
    chk("rst_enables", {27'd0, S, ALU_OUT, LOAD, LOADPC, done | undef}, 32'd0);
    repeat (3) @(negedge Clk);
    RESET = 1'b1;
    @(posedge Clk); #1;
    chk("ir_cu_run", {31'd0, IR_CU}, 32'd1);
    mon_en = 1;

    // Directed: skip on EQ, ADDS, CMP, ADD PC, immediate, LDR, then EQ passing
    dir_ir = '{32'h00810002, 32'hE0910002, 32'hE1510002, 32'hE081F002,
               32'hE2810001, 32'hE5910000, 32'h00810002};
    dir_fo = '{4'h3, 4'h4, 4'h6, 4'h9, 4'hF, 4'hF, 4'h1};
    for (int i = 0; i < 7; i++) issue(dir_ir[i], dir_fo[i]);

    // Randomized mix, mostly supported forms with assorted conditions
    for (int i = 0; i < 150; i++) begin
      ir = $urandom;
      if ($urandom_range(0, 7) != 0) ir[27:26] = 2'b00;
      if ($urandom_range(0, 7) != 0) ir[25] = 1'b0;
      if ($urandom_range(0, 7) != 0) ir[11:4] = 8'h00;
      if ($urandom_range(0, 5) == 0) ir[15:12] = 4'hF;
      if ($urandom_range(0, 2) == 0) ir[31:28] = 4'hE;
      if ($urandom_range(0, 3) == 0) begin
        IR_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge Clk);
        #1;
      end
      issue(ir, 4'($urandom));
    end
    issue(32'hE0910002, 4'hA);

    IR_valid = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    chk("cpsr_final", {28'd0, FLAGS}, {28'd0, cpsr_m});
    mon_en = 0;

    // Reset in the middle of ADDS: no write, CPSR back to reset value
    IR_in = 32'hE0910002; FLAGS_OUT = 4'h5; IR_valid = 1'b1;
    @(posedge Clk); #1;
    IR_valid = 1'b0;
    @(posedge Clk); #1;
    chk("abort_in_exec", {31'd0, ALU_OUT}, 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("abort_alu_out", {31'd0, ALU_OUT}, 32'd0);
    chk("abort_op", {27'd0, OP}, 32'd17);
    chk("abort_enables", {28'd0, S, LOAD, LOADPC, done}, 32'd0);
    chk("abort_ir_cu", {31'd0, IR_CU}, 32'd0);
    chk("abort_ready", {31'd0, IR_ready}, 32'd1);
    @(negedge Clk);
    RESET = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      wr_seen |= LOAD | LOADPC | done;
    end
    chk("post_reset_no_write", {31'd0, wr_seen}, 32'd0);
    chk("post_reset_ready", {31'd0, IR_ready}, 32'd1);
    chk("post_reset_flags", {28'd0, FLAGS}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
